// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared constants for the switch front end: edge-mode encodings, the default
// debounce window, and a helper that decides whether a level flip in a given
// direction is a reportable edge for a given mode.
// -----------------------------------------------------------------------------
package switch_pkg;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_BOTH = 2;

    // 10 ms at 25 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // True when a flip to the level given by 'rising' should be reported.
    function automatic logic edge_selected(input int mode, input logic rising);
        logic sel;
        sel = 1'b1;
        if (mode == EDGE_FALL) begin
            sel = !rising;
        end else if (mode == EDGE_RISE) begin
            sel = rising;
        end
        return sel;
    endfunction

endpackage : switch_pkg

// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
// Single-channel switch conditioner: optional two-flop synchroniser, a
// consecutive-difference counter and the accepted (debounced) level register.
// The level flips once the filter input has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any matching cycle restarts the window.
//
// Build option: SWITCH_TOGGLE_BANK_SYNC_EN inserts the synchroniser; without
// it i_Switch feeds the counter directly and must be synchronous to i_Clk.
//
// Ports:
//   i_Clk     system clock (posedge)
//   i_Rst_L   asynchronous active-low reset
//   i_Switch  raw switch input
//   o_Level   debounced level (registered)
//   o_Flip    high in the cycle whose closing edge flips o_Level
//   o_Rising  direction of that flip (1 = flips to high)
// -----------------------------------------------------------------------------
module debounce_filter
    import switch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Flip,
    output logic o_Rising
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_filt_in;
    logic             w_differs;
    logic             w_flip;
    logic [CNT_W-1:0] r_count;
    logic             r_level;

`ifdef SWITCH_TOGGLE_BANK_SYNC_EN
    logic [1:0] r_sync;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync <= {2{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[0], i_Switch};
        end
    end

    assign w_filt_in = r_sync[1];
`else
    assign w_filt_in = i_Switch;
`endif

    assign w_differs = (w_filt_in != r_level);
    // The counter only ever reaches CNT_LAST while differing, and is cleared
    // on that same cycle, so it can never wrap.
    assign w_flip    = w_differs && (r_count == CNT_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_count <= '0;
            r_level <= IDLE_LEVEL;
        end else if (!w_differs) begin
            r_count <= '0;
        end else if (w_flip) begin
            r_count <= '0;
            r_level <= w_filt_in;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // NOTE: o_Flip is combinational on purpose: the top registers its edge and
    // toggle state from it on the same clock edge that updates r_level, so all
    // three outputs change together with no extra cycle of latency.
    assign o_Level  = r_level;
    assign o_Flip   = w_flip;
    assign o_Rising = w_filt_in;

endmodule : debounce_filter

// File: rtl/switch_toggle_bank.sv
// -----------------------------------------------------------------------------
// switch_toggle_bank
// NUM_CH independent switch channels: each is synchronised (optionally),
// debounced, edge-qualified according to EDGE_MODE and drives a toggle flop.
// i_Clear zeroes every toggle state and wins over a coincident edge; edge
// pulses and debounce state are not affected by it.
//
// Build option: define SWITCH_TOGGLE_BANK_SYNC_EN to place a two-flop
// synchroniser in front of each debounce filter (board pins). Leave it
// undefined only when i_Switch is already synchronous to i_Clk.
//
// Ports:
//   i_Clk     system clock (posedge)
//   i_Rst_L   asynchronous active-low reset
//   i_Switch  [NUM_CH] raw switch inputs
//   i_Clear   synchronous clear of all toggle states
//   o_Level   [NUM_CH] debounced levels
//   o_Edge    [NUM_CH] one-cycle pulse per accepted edge matching EDGE_MODE
//   o_Toggle  [NUM_CH] toggle states
// -----------------------------------------------------------------------------
module switch_toggle_bank
    import switch_pkg::*;
#(
    parameter int   NUM_CH          = 4,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   EDGE_MODE       = EDGE_FALL,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic              i_Clear,
    output logic [NUM_CH-1:0] o_Level,
    output logic [NUM_CH-1:0] o_Edge,
    output logic [NUM_CH-1:0] o_Toggle
);

    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_flip;
    logic [NUM_CH-1:0] w_rising;
    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] r_edge;
    logic [NUM_CH-1:0] r_toggle;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_filter (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Switch (i_Switch[g]),
            .o_Level  (w_level[g]),
            .o_Flip   (w_flip[g]),
            .o_Rising (w_rising[g])
        );

        assign w_edge[g] = w_flip[g] && edge_selected(EDGE_MODE, w_rising[g]);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_edge   <= '0;
            r_toggle <= '0;
        end else begin
            r_edge   <= w_edge;
            r_toggle <= i_Clear ? '0 : (r_toggle ^ w_edge);
        end
    end

    assign o_Level  = w_level;
    assign o_Edge   = r_edge;
    assign o_Toggle = r_toggle;

endmodule : switch_toggle_bank

// File: tb/tb_switch_toggle_bank.sv
// -----------------------------------------------------------------------------
// tb_switch_toggle_bank
// Three instances (falling, rising, both-edge modes) share one stimulus.
// A window-based reference model tracks the expected outputs: a channel's
// level flips when the last DEBOUNCE_CYCLES filter-input samples all differ
// from it, where the filter input is the raw switch delayed by the
// synchroniser depth. Directed table rows and corner sequences come first,
// then randomised traffic.
// -----------------------------------------------------------------------------
module tb_switch_toggle_bank;

    localparam int NUM_CH = 4;
    localparam int DEB    = 4;
`ifdef SWITCH_TOGGLE_BANK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    // Clock edges from a raw change (driven before edge N, N counted) to flip.
    localparam int FLIP = DEB + LAT;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] sw;
    logic              clr;

    logic [NUM_CH-1:0] d_lvl [3];
    logic [NUM_CH-1:0] d_edg [3];
    logic [NUM_CH-1:0] d_tog [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar md = 0; md < 3; md++) begin : g_dut
        switch_toggle_bank #(
            .NUM_CH          (NUM_CH),
            .DEBOUNCE_CYCLES (DEB),
            .EDGE_MODE       (md),
            .IDLE_LEVEL      (1'b0)
        ) u_dut (
            .i_Clk    (clk),
            .i_Rst_L  (rst_n),
            .i_Switch (sw),
            .i_Clear  (clr),
            .o_Level  (d_lvl[md]),
            .o_Edge   (d_edg[md]),
            .o_Toggle (d_tog[md])
        );
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NUM_CH-1:0]        lvl;
        logic [2:0][NUM_CH-1:0]   edg;
        logic [2:0][NUM_CH-1:0]   tog;
    } mstate_t;

    logic [NUM_CH-1:0] raw_q [$];
    mstate_t           m;

    // Filter input 'back' edges ago (0 = this edge); idle before history.
    function automatic logic [NUM_CH-1:0] filt_at(input int back);
        int idx;
        idx = raw_q.size() - 1 - LAT - back;
        return (idx < 0) ? '0 : raw_q[idx];
    endfunction

    function automatic mstate_t model_next(input mstate_t cur, input logic clear);
        mstate_t           nx;
        logic [NUM_CH-1:0] s;
        logic              all_diff;
        logic              flip;
        logic              e;
        nx = cur;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                s = filt_at(k);
                if (s[ch] == cur.lvl[ch]) all_diff = 1'b0;
            end
            flip = all_diff;
            if (flip) nx.lvl[ch] = ~cur.lvl[ch];
            for (int md = 0; md < 3; md++) begin
                e = flip && ((md == 2) || (md == 1 && nx.lvl[ch]) || (md == 0 && !nx.lvl[ch]));
                nx.edg[md][ch] = e;
                nx.tog[md][ch] = clear ? 1'b0 : (cur.tog[md][ch] ^ e);
            end
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q.delete();
            m <= '0;
        end else begin
            raw_q.push_back(sw);
            m <= model_next(m, clr);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        for (int md = 0; md < 3; md++) begin
            check($sformatf("model_level_m%0d", md), 32'(d_lvl[md]), 32'(m.lvl));
            check($sformatf("model_edge_m%0d", md),  32'(d_edg[md]), 32'(m.edg[md]));
            check($sformatf("model_tog_m%0d", md),   32'(d_tog[md]), 32'(m.tog[md]));
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_model();
        end
    endtask

    typedef struct {
        logic [NUM_CH-1:0] sw;
        logic              clr;
        int                n;
        logic [NUM_CH-1:0] lvl;
        logic [NUM_CH-1:0] edg_f;
        logic [NUM_CH-1:0] tog_f;
        logic [NUM_CH-1:0] edg_b;
        logic [NUM_CH-1:0] tog_b;
    } vec_t;

    vec_t vecs [7];
    logic edge1_seen;

    initial begin
        sw    = '0;
        clr   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int md = 0; md < 3; md++) begin
            check("reset_level", 32'(d_lvl[md]), 32'h0);
            check("reset_edge",  32'(d_edg[md]), 32'h0);
            check("reset_tog",   32'(d_tog[md]), 32'h0);
        end
        rst_n = 1'b1;

        // Clean press then release on ch0, then a clear.
        vecs[0] = '{4'b0001, 1'b0, FLIP-1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0001, 1'b0, 1,      4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        vecs[2] = '{4'b0001, 1'b0, 1,      4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        vecs[3] = '{4'b0000, 1'b0, FLIP-1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        vecs[4] = '{4'b0000, 1'b0, 1,      4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        vecs[5] = '{4'b0000, 1'b0, 1,      4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[6] = '{4'b0000, 1'b1, 1,      4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int v = 0; v < 7; v++) begin
            sw  = vecs[v].sw;
            clr = vecs[v].clr;
            cycle(vecs[v].n);
            check($sformatf("vec%0d_level", v),  32'(d_lvl[0]), 32'(vecs[v].lvl));
            check($sformatf("vec%0d_edge_f", v), 32'(d_edg[0]), 32'(vecs[v].edg_f));
            check($sformatf("vec%0d_tog_f", v),  32'(d_tog[0]), 32'(vecs[v].tog_f));
            check($sformatf("vec%0d_edge_b", v), 32'(d_edg[2]), 32'(vecs[v].edg_b));
            check($sformatf("vec%0d_tog_b", v),  32'(d_tog[2]), 32'(vecs[v].tog_b));
        end
        clr = 1'b0;

        // Asynchronous reset in the middle of a debounce window.
        sw = 4'b0001;
        cycle(FLIP);
        sw = 4'b0000;
        cycle(2);
        #2 rst_n = 1'b0;
        #1;
        for (int md = 0; md < 3; md++) begin
            check("midrst_level", 32'(d_lvl[md]), 32'h0);
            check("midrst_edge",  32'(d_edg[md]), 32'h0);
            check("midrst_tog",   32'(d_tog[md]), 32'h0);
        end
        sw = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FLIP - 1; i++) begin
            cycle(1);
            check("post_rst_no_edge", 32'(d_edg[2]), 32'h0);
        end
        cycle(2);

        // Bounce on ch1: never long enough to be accepted.
        edge1_seen = 1'b0;
        for (int r = 0; r < 10; r++) begin
            sw[1] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cycle(1);
                edge1_seen = edge1_seen | d_edg[2][1] | d_edg[0][1];
            end
            sw[1] = 1'b0;
            cycle(1);
            edge1_seen = edge1_seen | d_edg[2][1] | d_edg[0][1];
            check("bounce_level1", 32'(d_lvl[2][1]), 32'h0);
        end
        check("bounce_edge1", 32'(edge1_seen), 32'h0);

        // Simultaneous release on ch2/ch3 with clear on the pulse edge.
        sw[3:2] = 2'b11;
        cycle(FLIP + 1);
        sw[3:2] = 2'b00;
        cycle(FLIP - 1);
        clr = 1'b1;
        cycle(1);
        check("simul_edge_f", 32'(d_edg[0][3:2]), 32'h3);
        check("simul_tog_f",  32'(d_tog[0][3:2]), 32'h0);
        check("simul_edge_b", 32'(d_edg[2][3:2]), 32'h3);
        check("simul_tog_b",  32'(d_tog[2][3:2]), 32'h0);
        clr = 1'b0;
        cycle(1);
        check("simul_edge_gone", 32'(d_edg[0][3:2]), 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 5) == 0) sw[ch] = ~sw[ch];
            end
            clr = ($urandom_range(0, 15) == 0);
            cycle(1);
        end
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_switch_toggle_bank
